// File: rtl/bubble_pkg.sv
// Shared widths, slot record layout and the free-slot search used by the
// bubble renderer.
package bubble_pkg;
  localparam int COORD_W   = 12;
  localparam int DIFF_W    = 13;
  localparam int SQ_W      = 27;
  localparam int MAX_SLOTS = 16;
  localparam int IDX_W     = 4;

  typedef struct packed {
    logic                      active;
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
  } slot_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } free_t;

  // Scans downward so the last hit, and therefore the result, is the lowest free index.
  function automatic free_t find_free(input logic [MAX_SLOTS-1:0] busy);
    free_t res;
    res = '0;
    for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        res.found = 1'b1;
        res.idx   = IDX_W'(i);
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/bubble_ring_hit.sv
// Two-stage annulus hit test for one bubble slot: stage 1 registers the
// offsets, stage 2 registers the squared-distance compare.
module bubble_ring_hit
  import bubble_pkg::*;
#(
  parameter int R_OUTER = 7,
  parameter int R_INNER = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [10:0]        i_hcount,
  input  logic signed [10:0]        i_vcount,
  input  logic signed [COORD_W-1:0] i_x,
  input  logic signed [COORD_W-1:0] i_y,
  input  logic                      i_active,
  output logic                      o_hit
);
  localparam logic [SQ_W-1:0] LO_SQ = SQ_W'(R_INNER * R_INNER);
  localparam logic [SQ_W-1:0] HI_SQ = SQ_W'(R_OUTER * R_OUTER);

  logic signed [DIFF_W-1:0] r_dx;
  logic signed [DIFF_W-1:0] r_dy;
  logic                     r_active;
  logic                     r_hit;
  logic signed [SQ_W-1:0]   w_dxExt;
  logic signed [SQ_W-1:0]   w_dyExt;
  logic [SQ_W-1:0]          w_d2;

  assign w_dxExt = SQ_W'(r_dx);
  assign w_dyExt = SQ_W'(r_dy);
  assign w_d2    = w_dxExt * w_dxExt + w_dyExt * w_dyExt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dx     <= '0;
      r_dy     <= '0;
      r_active <= 1'b0;
      r_hit    <= 1'b0;
    end else begin
      r_dx     <= DIFF_W'(i_hcount) - DIFF_W'(i_x);
      r_dy     <= DIFF_W'(i_vcount) - DIFF_W'(i_y);
      r_active <= i_active;
      r_hit    <= r_active && (w_d2 >= LO_SQ) && (w_d2 <= HI_SQ);
    end
  end

  assign o_hit = r_hit;
endmodule

// File: rtl/bubble_field.sv
// Multi-bubble ring renderer: slot array with spawn allocator and per-frame
// rise, plus the per-pixel OR of all slot ring hits.
module bubble_field
  import bubble_pkg::*;
#(
  parameter int NUM_BUBBLES = 4,
  parameter int R_OUTER     = 7,
  parameter int R_INNER     = 5,
  parameter int RISE_STEP   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_tick,
  input  logic                      spawn_valid,
  input  logic signed [COORD_W-1:0] spawn_x,
  input  logic signed [COORD_W-1:0] spawn_y,
  output logic                      spawn_ready,
  input  logic                      blank,
  input  logic signed [10:0]        hcount,
  input  logic signed [10:0]        vcount,
  output logic                      bubble,
  output logic                      blank_d,
  output logic [4:0]                active_count
);
  localparam logic signed [DIFF_W-1:0] MIN_Y = DIFF_W'(-R_OUTER);
  localparam logic signed [DIFF_W-1:0] STEP  = DIFF_W'(RISE_STEP);

  slot_t                    r_slot [NUM_BUBBLES];
  slot_t                    w_next [NUM_BUBBLES];
  logic signed [DIFF_W-1:0] w_newY [NUM_BUBBLES];
  logic [MAX_SLOTS-1:0]     w_busy;
  free_t                    w_free;
  logic                     w_accept;
  logic [4:0]               w_nextCount;
  logic [4:0]               r_count;
  logic [NUM_BUBBLES-1:0]   w_hit;
  logic                     r_blankS1;
  logic                     r_blankD;

  // Slots beyond NUM_BUBBLES read as busy so the allocator never picks them.
  always_comb begin
    w_busy = '1;
    for (int i = 0; i < NUM_BUBBLES; i++) begin
      w_busy[i] = r_slot[i].active;
    end
  end

  assign w_free      = find_free(w_busy);
  assign spawn_ready = w_free.found;
  assign w_accept    = spawn_valid & w_free.found;

  // Spawn is applied after the rise so a freshly written slot keeps spawn_y as given.
  always_comb begin
    w_nextCount = '0;
    for (int i = 0; i < NUM_BUBBLES; i++) begin
      w_newY[i] = DIFF_W'($signed(r_slot[i].y)) - STEP;
      w_next[i] = r_slot[i];
      if (frame_tick && r_slot[i].active) begin
        if (w_newY[i] < MIN_Y) begin
          w_next[i].active = 1'b0;
        end else begin
          w_next[i].y = r_slot[i].y - COORD_W'(RISE_STEP);
        end
      end
      if (w_accept && (w_free.idx == IDX_W'(i))) begin
        w_next[i].active = 1'b1;
        w_next[i].x      = spawn_x;
        w_next[i].y      = spawn_y;
      end
      w_nextCount = w_nextCount + 5'(w_next[i].active);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BUBBLES; i++) begin
        r_slot[i] <= '0;
      end
      r_count   <= '0;
      r_blankS1 <= 1'b1;
      r_blankD  <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_BUBBLES; i++) begin
        r_slot[i] <= w_next[i];
      end
      r_count   <= w_nextCount;
      r_blankS1 <= blank;
      r_blankD  <= r_blankS1;
    end
  end

  for (genvar g = 0; g < NUM_BUBBLES; g++) begin : g_ring
    bubble_ring_hit #(
      .R_OUTER (R_OUTER),
      .R_INNER (R_INNER)
    ) u_ring (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_hcount (hcount),
      .i_vcount (vcount),
      .i_x      (r_slot[g].x),
      .i_y      (r_slot[g].y),
      .i_active (r_slot[g].active),
      .o_hit    (w_hit[g])
    );
  end

  assign bubble       = ~r_blankD & (|w_hit);
  assign blank_d      = r_blankD;
  assign active_count = r_count;
endmodule

// File: tb/tb_bubble_field.sv
// Self-checking bench for bubble_field: table-driven pixel vectors through a
// two-deep scoreboard, plus hand-written spawn/rise/reset sequences.
module tb_bubble_field;
  typedef struct {
    bit    chk;
    bit    expB;
    bit    expBd;
    string tag;
  } sbEntry_t;

  typedef struct {
    int    h;
    int    v;
    bit    blk;
    bit    expB;
    string tag;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               frame_tick = 1'b0;
  logic               spawn_valid = 1'b0;
  logic signed [11:0] spawn_x = '0;
  logic signed [11:0] spawn_y = '0;
  logic               spawn_ready;
  logic               blank = 1'b1;
  logic signed [10:0] hcount = '0;
  logic signed [10:0] vcount = '0;
  logic               bubble;
  logic               blank_d;
  logic [4:0]         active_count;

  int       checks = 0;
  int       errors = 0;
  sbEntry_t sbQueue[$];
  vec_t     vecQ[$];

  always #5 clk = ~clk;

  bubble_field #(
    .NUM_BUBBLES (4),
    .R_OUTER     (7),
    .R_INNER     (5),
    .RISE_STEP   (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .spawn_valid  (spawn_valid),
    .spawn_x      (spawn_x),
    .spawn_y      (spawn_y),
    .spawn_ready  (spawn_ready),
    .blank        (blank),
    .hcount       (hcount),
    .vcount       (vcount),
    .bubble       (bubble),
    .blank_d      (blank_d),
    .active_count (active_count)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // One pixel per cycle; the pixel driven two calls ago is compared first.
  task automatic applyStimulus(input int h, input int v, input bit blk,
                               input bit chk, input bit expB, input string tag);
    sbEntry_t e;
    @(posedge clk);
    #1;
    if (sbQueue.size() == 2) begin
      e = sbQueue.pop_front();
      if (e.chk) begin
        checkOutput({e.tag, " bubble"}, int'(bubble), int'(e.expB));
        checkOutput({e.tag, " blank_d"}, int'(blank_d), int'(e.expBd));
      end
    end
    hcount = 11'(h);
    vcount = 11'(v);
    blank  = blk;
    e.chk   = chk;
    e.expB  = expB;
    e.expBd = blk;
    e.tag   = tag;
    sbQueue.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(-1000, -1000, 1'b1, 1'b0, 1'b0, "idle");
  endtask

  task automatic spawnAt(input int x, input int y);
    spawn_x     = 12'(x);
    spawn_y     = 12'(y);
    spawn_valid = 1'b1;
    idle(1);
    spawn_valid = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    sbQueue.delete();
    idle(2);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mkVec(input int h, input int v, input bit blk,
                                 input bit expB, input string tag);
    vec_t r;
    r.h = h; r.v = v; r.blk = blk; r.expB = expB; r.tag = tag;
    return r;
  endfunction

  initial begin
    vecQ.push_back(mkVec(100, 100, 1'b0, 1'b0, "centre"));
    vecQ.push_back(mkVec(104, 100, 1'b0, 1'b0, "d4"));
    vecQ.push_back(mkVec(105, 100, 1'b0, 1'b1, "d5 inner edge"));
    vecQ.push_back(mkVec(107, 100, 1'b0, 1'b1, "d7 outer edge"));
    vecQ.push_back(mkVec(108, 100, 1'b0, 1'b0, "d8"));
    vecQ.push_back(mkVec(100,  93, 1'b0, 1'b1, "dy-7"));
    vecQ.push_back(mkVec(100,  92, 1'b0, 1'b0, "dy-8"));
    vecQ.push_back(mkVec(103, 104, 1'b0, 1'b1, "d2=25 diag"));
    vecQ.push_back(mkVec(102, 104, 1'b0, 1'b0, "d2=20 diag"));
    vecQ.push_back(mkVec(105, 105, 1'b0, 1'b0, "d2=50 diag"));
    vecQ.push_back(mkVec(105, 100, 1'b1, 1'b0, "blanked hit"));
    vecQ.push_back(mkVec(107, 100, 1'b0, 1'b1, "unblanked hit"));

    idle(3);
    checkOutput("reset bubble", int'(bubble), 0);
    checkOutput("reset blank_d", int'(blank_d), 1);
    checkOutput("reset spawn_ready", int'(spawn_ready), 1);
    checkOutput("reset active_count", int'(active_count), 0);
    rst_n = 1'b1;
    idle(1);

    spawnAt(100, 100);
    checkOutput("count after first spawn", int'(active_count), 1);
    foreach (vecQ[i])
      applyStimulus(vecQ[i].h, vecQ[i].v, vecQ[i].blk, 1'b1, vecQ[i].expB, vecQ[i].tag);
    idle(2);

    spawnAt(500, 500);
    spawnAt(600, -7);
    checkOutput("ready with 3 active", int'(spawn_ready), 1);
    checkOutput("count with 3 active", int'(active_count), 3);
    spawnAt(700, 500);
    checkOutput("ready when full", int'(spawn_ready), 0);
    checkOutput("count when full", int'(active_count), 4);
    spawn_x     = 12'sd800;
    spawn_y     = 12'sd300;
    spawn_valid = 1'b1;
    repeat (3) begin
      idle(1);
      checkOutput("held request count", int'(active_count), 4);
      checkOutput("held request ready", int'(spawn_ready), 0);
    end
    frame_tick = 1'b1;
    idle(1);
    frame_tick = 1'b0;
    checkOutput("same-edge tick count", int'(active_count), 3);
    checkOutput("ready after retire", int'(spawn_ready), 1);
    idle(1);
    spawn_valid = 1'b0;
    checkOutput("late accept count", int'(active_count), 4);
    checkOutput("late accept ready", int'(spawn_ready), 0);
    applyStimulus(800, 307, 1'b0, 1'b1, 1'b1, "spawn_y kept dy7");
    applyStimulus(800, 292, 1'b0, 1'b1, 1'b0, "spawn_y kept dy-8");
    applyStimulus(100, 107, 1'b0, 1'b1, 1'b0, "risen slot dy8");
    applyStimulus(100,  92, 1'b0, 1'b1, 1'b1, "risen slot dy-7");
    idle(2);

    doReset();
    checkOutput("count after reset", int'(active_count), 0);
    spawnAt(300, 200);
    spawnAt(306, 200);
    applyStimulus(303, 200, 1'b0, 1'b1, 1'b0, "between rings");
    applyStimulus(311, 200, 1'b0, 1'b1, 1'b1, "second ring d5");
    applyStimulus(295, 200, 1'b0, 1'b1, 1'b1, "first ring d5");
    applyStimulus(306, 207, 1'b0, 1'b1, 1'b1, "second ring dy7");
    idle(2);
    spawnAt(100, 100);
    checkOutput("three active", int'(active_count), 3);
    repeat (4) applyStimulus(311, 200, 1'b0, 1'b1, 1'b1, "pre-reset hit");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset bubble", int'(bubble), 0);
    checkOutput("async reset blank_d", int'(blank_d), 1);
    checkOutput("async reset ready", int'(spawn_ready), 1);
    checkOutput("async reset count", int'(active_count), 0);
    sbQueue.delete();
    idle(2);
    rst_n = 1'b1;
    applyStimulus(311, 200, 1'b0, 1'b1, 1'b0, "no stale hit a");
    applyStimulus(295, 200, 1'b0, 1'b1, 1'b0, "no stale hit b");
    applyStimulus(105, 100, 1'b0, 1'b1, 1'b0, "no stale hit c");
    idle(2);

    spawnAt(50, 2);
    for (int k = 1; k <= 10; k++) begin
      frame_tick = 1'b1;
      idle(1);
      frame_tick = 1'b0;
      checkOutput($sformatf("count after tick %0d", k), int'(active_count), (k < 10) ? 1 : 0);
      if (k == 9) begin
        applyStimulus(50, 0, 1'b0, 1'b1, 1'b1, "y=-7 ring");
        applyStimulus(50, 1, 1'b0, 1'b1, 1'b0, "y=-7 gap");
        idle(2);
      end
    end
    checkOutput("ready after rise retire", int'(spawn_ready), 1);
    applyStimulus(50, 0, 1'b0, 1'b1, 1'b0, "retired slot");
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
